// File: rtl/timed_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : timed_decoder
//  Description : Registered one-hot select generator with a valid/ready
//                request port, per-request hold time and out-of-range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module timed_decoder #(
   parameter int ADDR_WIDTH  = 3,
   parameter int NUM_OUTPUTS = 2**ADDR_WIDTH,
   parameter int HOLD_CYCLES = 1,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDR_WIDTH-1:0]  addr,
   output logic [NUM_OUTPUTS-1:0] sel,
   output logic                   busy,
   output logic                   err
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // One extra bit so the range compare also works when NUM_OUTPUTS == 2**ADDR_WIDTH.
   localparam logic [ADDR_WIDTH:0]  c_num_outputs = (ADDR_WIDTH+1)'(NUM_OUTPUTS);
   localparam logic [CNT_WIDTH-1:0] c_cnt_load    = CNT_WIDTH'(HOLD_CYCLES - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [NUM_OUTPUTS-1:0]   r_sel;
   logic [NUM_OUTPUTS-1:0]   w_sel_nxt;
   logic [NUM_OUTPUTS-1:0]   w_dec;
   logic [CNT_WIDTH-1:0]     r_cnt;
   logic [CNT_WIDTH-1:0]     w_cnt_nxt;
   logic                     r_err;
   logic                     w_err_nxt;
   logic                     w_accept;
   logic                     w_in_range;
   logic                     w_cnt_zero;

   for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_dec
      assign w_dec[gi] = (addr == ADDR_WIDTH'(gi));
   end

   assign w_in_range = ({1'b0, addr} < c_num_outputs);
   assign w_cnt_zero = (r_cnt == '0);
   assign in_ready   = enable & ~reset & ((r_state == IDLE) | ((r_state == ACTIVE) & w_cnt_zero));
   assign w_accept   = in_valid & in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
         w_sel_nxt   = '0;
         w_cnt_nxt   = '0;
      end else if (w_accept) begin
         // Loading straight over the last ACTIVE cycle gives gap-free back-to-back strobes.
         if (w_in_range) begin
            w_state_nxt = ACTIVE;
            w_sel_nxt   = w_dec;
            w_cnt_nxt   = c_cnt_load;
         end else begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b1;
         end
      end else if (r_state == ACTIVE) begin
         if (w_cnt_zero) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
         end else begin
            w_cnt_nxt   = r_cnt - 1'b1;
         end
      end
   end

   assign sel  = r_sel;
   assign busy = |r_sel;
   assign err  = r_err;

endmodule
`default_nettype wire
